// File: rtl/vga_pkg.sv
// Shared types and default SVGA 800x600 timing for the VGA stream sink.
// Raster totals are derived from the individual timing segments.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam int DEF_IMG_W  = 540;
    localparam int DEF_IMG_H  = 540;
    localparam int DEF_H_ACT  = 800;
    localparam int DEF_H_FP   = 40;
    localparam int DEF_H_SYNC = 128;
    localparam int DEF_H_BP   = 88;
    localparam int DEF_V_ACT  = 600;
    localparam int DEF_V_FP   = 1;
    localparam int DEF_V_SYNC = 4;
    localparam int DEF_V_BP   = 23;

    function automatic int h_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp,
                                   input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// A push while full is accepted only when a pop frees a slot that cycle.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_rd    = i_pop && !o_empty;
    assign w_wr    = i_push && (!o_full || w_rd);

    // Storage array, written on accepted pushes only
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wr <= r_wr + 1'b1;
            if (w_rd) r_rd <= r_rd + 1'b1;
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/vga_stream_sink.sv
// Buffers a grayscale pixel stream and paints it into the top-left
// corner of a free-running VGA raster with registered sync and colour.
module vga_stream_sink
    import vga_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int H_ACT      = DEF_H_ACT,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACT      = DEF_V_ACT,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit SYNC_POL   = 1'b1,
    parameter int CLK_DIV    = 1,
    parameter int FIFO_DEPTH = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_i,
    input  logic       pixel_en_i,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic [3:0] vga_r_o,
    output logic [3:0] vga_g_o,
    output logic [3:0] vga_b_o,
    output logic       frame_done_o,
    output logic       overflow_o,
    output logic       underflow_o,
    output logic [1:0] state_o
);

    localparam int H_TOTAL = h_total(H_ACT, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACT, V_FP, V_SYNC, V_BP);
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(IMG_W * IMG_H);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] HS_S   = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_E   = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_S   = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_E   = VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [HW-1:0] WIN_H  = HW'(IMG_W);
    localparam logic [VW-1:0] WIN_V  = VW'(IMG_H);
    localparam logic [PW-1:0] PIX_LAST = PW'(IMG_W * IMG_H - 1);

    logic [DW-1:0] r_div;
    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic [PW-1:0] r_pix;
    logic          r_fd_pend;
    state_t        r_state;
    state_t        w_state_nx;

    logic          w_tick;
    logic          w_win;
    logic          w_start;
    logic          w_active;
    logic          w_slot;
    logic          w_pop;
    logic          w_last;
    logic          w_hs;
    logic          w_vs;
    logic [7:0]    w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic [3:0]    w_col;
    logic          w_unused_lo;

    assign w_tick      = (r_div == DW'(CLK_DIV - 1));
    assign w_win       = (r_h < WIN_H) && (r_v < WIN_V);
    assign w_hs        = (r_h >= HS_S) && (r_h < HS_E);
    assign w_vs        = (r_v >= VS_S) && (r_v < VS_E);
    assign w_col       = w_pop ? w_head[7:4] : 4'h0;
    assign w_unused_lo = &w_head[3:0];
    assign state_o     = r_state;

    sync_fifo_fwft #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (pixel_en_i),
        .i_data  (pixel_i),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Pixel tick divider
    always_ff @(posedge clk) begin
        if (rst)         r_div <= '0;
        else if (w_tick) r_div <= '0;
        else             r_div <= r_div + 1'b1;
    end

    // Free-running raster counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            if (r_h == H_LAST) begin
                r_h <= '0;
                r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
            end else begin
                r_h <= r_h + 1'b1;
            end
        end
    end

    // Next state; a frame start at (0,0) already consumes that slot
    always_comb begin
        w_state_nx = r_state;
        w_start    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (pixel_en_i) w_state_nx = ST_PRIME;
            end
            ST_PRIME: begin
                if (w_tick && r_h == '0 && r_v == '0 &&
                    w_count >= CW'(IMG_W)) begin
                    w_start    = 1'b1;
                    w_state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nx = ST_RUN;
            end
            default: w_state_nx = ST_IDLE;
        endcase
        w_active = (r_state == ST_RUN) || w_start;
        w_slot   = w_tick && w_active && w_win;
        w_pop    = w_slot && !w_empty;
        w_last   = w_slot && (r_pix == PIX_LAST);
        if (w_last) w_state_nx = ST_PRIME;
    end

    // State, frame pixel count, frame-done pulse and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_pix        <= '0;
            r_fd_pend    <= 1'b0;
            frame_done_o <= 1'b0;
            overflow_o   <= 1'b0;
            underflow_o  <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_fd_pend    <= w_last;
            frame_done_o <= r_fd_pend;
            if (w_last)      r_pix <= '0;
            else if (w_slot) r_pix <= r_pix + 1'b1;
            if (pixel_en_i && w_full && !w_pop) overflow_o <= 1'b1;
            if (w_slot && w_empty) underflow_o <= 1'b1;
        end
    end

    // Registered sync and colour, aligned to the same raster position
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync_o <= ~SYNC_POL;
            vsync_o <= ~SYNC_POL;
            vga_r_o <= 4'h0;
            vga_g_o <= 4'h0;
            vga_b_o <= 4'h0;
        end else if (w_tick) begin
            hsync_o <= w_hs ? SYNC_POL : ~SYNC_POL;
            vsync_o <= w_vs ? SYNC_POL : ~SYNC_POL;
            vga_r_o <= w_col;
            vga_g_o <= w_col;
            vga_b_o <= w_col;
        end
    end

endmodule

// File: tb/tb_vga_stream_sink.sv
// Directed bench for vga_stream_sink on a tiny 12x6 raster with a
// 4x2 image window and an 8-entry FIFO, scoreboarded against a model.
module tb_vga_stream_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pixel_i;
    logic       pixel_en_i;
    logic       hsync_o;
    logic       vsync_o;
    logic [3:0] vga_r_o;
    logic [3:0] vga_g_o;
    logic [3:0] vga_b_o;
    logic       frame_done_o;
    logic       overflow_o;
    logic       underflow_o;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    // model of the design, advanced once per clock edge
    int         mh, mv, mst, mcnt, mpix;
    bit         mfdp, mov, mun;
    logic [3:0] sb[$];
    logic       e_hs, e_vs, e_fd;
    logic [3:0] e_col;
    int         fd_seen;
    bit         p;

    vga_stream_sink #(
        .IMG_W(4), .IMG_H(2),
        .H_ACT(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .CLK_DIV(1), .FIFO_DEPTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pixel_i      (pixel_i),
        .pixel_en_i   (pixel_en_i),
        .hsync_o      (hsync_o),
        .vsync_o      (vsync_o),
        .vga_r_o      (vga_r_o),
        .vga_g_o      (vga_g_o),
        .vga_b_o      (vga_b_o),
        .frame_done_o (frame_done_o),
        .overflow_o   (overflow_o),
        .underflow_o  (underflow_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pred_pop();
        bit win, act;
        win = (mh < 4) && (mv < 2);
        act = (mst == 2) || (mst == 1 && mh == 0 && mv == 0 && mcnt >= 4);
        return act && win && (mcnt > 0);
    endfunction

    task automatic model_edge(input logic r, input logic en,
                              input logic [7:0] d);
        bit win, start, act, slot, pop;
        if (r) begin
            mh = 0; mv = 0; mst = 0; mcnt = 0; mpix = 0;
            mfdp = 0; mov = 0; mun = 0;
            sb.delete();
            e_hs = 0; e_vs = 0; e_col = 0; e_fd = 0;
            return;
        end
        win   = (mh < 4) && (mv < 2);
        start = (mst == 1) && mh == 0 && mv == 0 && mcnt >= 4;
        act   = (mst == 2) || start;
        slot  = act && win;
        pop   = slot && (mcnt > 0);
        e_hs  = (mh >= 9) && (mh < 11);
        e_vs  = (mv == 4);
        e_col = pop ? sb.pop_front() : 4'h0;
        if (slot && !pop) mun = 1;
        e_fd = mfdp;
        mfdp = 0;
        if (en) begin
            if (mcnt < 8 || pop) sb.push_back(d[7:4]);
            else mov = 1;
        end
        mcnt = sb.size();
        if (mst == 0 && en) mst = 1;
        if (start) mst = 2;
        if (slot) begin
            if (mpix == 7) begin
                mpix = 0;
                mst  = 1;
                mfdp = 1;
            end else begin
                mpix++;
            end
        end
        mh++;
        if (mh == 12) begin
            mh = 0;
            mv = (mv == 5) ? 0 : mv + 1;
        end
    endtask

    task automatic step(input logic r, input logic en, input logic [7:0] d);
        rst        = r;
        pixel_en_i = en;
        pixel_i    = d;
        model_edge(r, en, d);
        @(posedge clk);
        #1;
        chk("hsync", 32'(hsync_o), 32'(e_hs));
        chk("vsync", 32'(vsync_o), 32'(e_vs));
        chk("colour", 32'({vga_r_o, vga_g_o, vga_b_o}),
            32'({e_col, e_col, e_col}));
        chk("frame_done", 32'(frame_done_o), 32'(e_fd));
        chk("overflow", 32'(overflow_o), 32'(mov));
        chk("underflow", 32'(underflow_o), 32'(mun));
        chk("state", 32'(state_o), 32'(mst));
        if (frame_done_o === 1'b1) fd_seen++;
        rst        = 1'b0;
        pixel_en_i = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        pixel_en_i = 1'b0;
        pixel_i    = 8'h00;
        fd_seen    = 0;

        // reset held three clocks, then free-running raster
        repeat (3) step(1'b1, 1'b0, 8'h00);
        repeat (14) step(1'b0, 1'b0, 8'h00);

        // normal frame: 0x10..0x80
        step(1'b1, 1'b0, 8'h00);
        fd_seen = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(16 * (i + 1)));
        repeat (150) step(1'b0, 1'b0, 8'h00);
        chk("norm_fd_once", 32'(fd_seen), 32'd1);
        chk("norm_state_prime", 32'(state_o), 32'd1);

        // underflow: only one row supplied
        step(1'b1, 1'b0, 8'h00);
        fd_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h95 + 8'(16 * i)));
        repeat (150) step(1'b0, 1'b0, 8'h00);
        chk("uf_flag", 32'(underflow_o), 32'd1);
        chk("uf_fd_once", 32'(fd_seen), 32'd1);

        // overflow: nine pushes into an eight-entry FIFO
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'(8'h13 + 8'(16 * i)));
        chk("of_count", 32'(dut.u_fifo.o_count), 32'd8);
        chk("of_flag", 32'(overflow_o), 32'd1);
        repeat (150) step(1'b0, 1'b0, 8'h00);

        // push exactly when popping while full during RUN
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h27 + 8'(16 * i)));
        for (int i = 0; i < 150; i++) begin
            p = pred_pop();
            step(1'b0, p, 8'(8'hC0 + 8'(i)));
        end
        chk("pp_count", 32'(dut.u_fifo.o_count), 32'd8);
        chk("pp_no_overflow", 32'(overflow_o), 32'd0);

        // reset in the middle of a displayed frame
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h3A + 8'(16 * i)));
        for (int i = 0; i < 200 && !(mst == 2 && mpix == 3); i++)
            step(1'b0, 1'b0, 8'h00);
        chk("mid_in_run", 32'(state_o), 32'd2);
        step(1'b1, 1'b0, 8'h00);
        chk("mid_fifo_empty", 32'(dut.u_fifo.o_empty), 32'd1);
        chk("mid_colour", 32'({vga_r_o, vga_g_o, vga_b_o}), 32'd0);
        repeat (20) step(1'b0, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_stream_sink.md
# vga_stream_sink

Receiving end of the pixel stream (`pixel`/`pixel_en`) produced by the memory controller in mode 1 and by the Sobel core in mode 2. The block buffers incoming 8-bit grayscale pixels in a FIFO and generates SVGA raster timing. It places the image window in the top-left of the visible area and drives 12-bit VGA colour plus sync pulses. It is the final stage before the board's VGA connector.

## Interface
- `IMG_W`, 540: image width in pixels
- `IMG_H`, 540: image height in pixels
- `H_ACT`/`H_FP`/`H_SYNC`/`H_BP`, 800/40/128/88: horizontal timing (pixel ticks)
- `V_ACT`/`V_FP`/`V_SYNC`/`V_BP`, 600/1/4/23: vertical timing (lines)
- `SYNC_POL`, 1: active level of `hsync_o`/`vsync_o`
- `CLK_DIV`, 1: system clocks per pixel tick (1 = every clock)
- `FIFO_DEPTH`, 1024: buffer entries, power of two, ≥ `IMG_W`
- `clk` input 1: system clock, all logic on rising edge
- `rst` input 1: synchronous, active-high reset
- `pixel_i` input 8: grayscale pixel, raster order
- `pixel_en_i` input 1: `pixel_i` valid this cycle; no backpressure exists
- `hsync_o` output 1: horizontal sync
- `vsync_o` output 1: vertical sync
- `vga_r_o`, `vga_g_o`, `vga_b_o` output 4 each: colour, each = displayed pixel[7:4]
- `frame_done_o` output 1: one-cycle pulse after the last image pixel of a frame is displayed
- `overflow_o` output 1: sticky, a push was dropped
- `underflow_o` output 1: sticky, a display slot found the FIFO empty
- `state_o` output 2: debug, current FSM state

## Operation
- Raster counters `h_cnt` run 0..H_TOTAL−1 and `v_cnt` run 0..V_TOTAL−1.
  - H_TOTAL = sum of the H params (1056); V_TOTAL = sum of the V params (628).
  - Both advance only on pixel ticks and run continuously from reset, independent of state, so the monitor stays locked.
- Sync is active for h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC), and likewise for v_cnt.
- Image window is h_cnt < IMG_W and v_cnt < IMG_H. The rest of the active area and all blanking output 0.
- FIFO push: on every cycle with `pixel_en_i`.
  - A push when full is dropped and sets `overflow_o`. This applies only if there is no pop in the same cycle.
  - Push and pop in the same cycle when full is legal; the count is unchanged.
- FSM states:
  - IDLE (0): leaves on the first push, to PRIME.
  - PRIME (1): goes to RUN on the tick where h_cnt=0 and v_cnt=0 with FIFO count ≥ IMG_W.
  - RUN (2): pops one entry per tick inside the image window.
    - Empty at pop time: display 0, no pop, set `underflow_o`. The raster position still advances, so later pixels are not shifted.
    - After IMG_W·IMG_H window ticks, pulse `frame_done_o` and go to PRIME.
- In PRIME and IDLE the window shows 0 and nothing is popped.
- Sticky flags clear only on `rst`.
- Reset mid-frame: counters, FSM, flags and FIFO contents are all cleared. Outputs take reset values on the next edge.

## Timing
- Reset values:
  - sync outputs at the inactive level (`!SYNC_POL`)
  - colour 0
  - `frame_done_o`, `overflow_o`, `underflow_o` all 0
  - `state_o`=0
  - counters 0, FIFO empty
- All outputs are registered. Sync and colour for raster position (h,v) appear together one clock after the counters hold (h,v), so they stay aligned.
- FIFO is first-word-fall-through. The head is valid in the cycle after the push; the pop takes effect on the same edge as the colour register load.
- Push-to-count latency is 1 clock. The PRIME→RUN check uses the registered count.
- `frame_done_o` asserts on the clock after the final image pixel's colour is registered.
- With CLK_DIV>1, counters, pops and output registers update only on tick cycles. Pushes occur on any cycle.

## Structure
- Shared package `vga_pkg`:
  - state enum {IDLE, PRIME, RUN}
  - default SVGA timing constants
  - H_TOTAL/V_TOTAL functions
- One sub-module: `sync_fifo_fwft` (parameterised width/depth, count, full/empty), reusable elsewhere.
- Counter/sync generation, FSM, window compare and output registers live in the top.

## Test plan
Small config for all scenarios unless noted: IMG_W=4, IMG_H=2, H 8/1/2/1, V 3/1/1/1, FIFO_DEPTH=8.
- Reset: hold `rst` 3 clocks → all outputs at reset values, `state_o`=0. Release → hsync active at h_cnt 9..10, one clock delayed.
- Normal frame: push 8 pixels 0x10..0x80, then idle → RUN at the next (0,0). Colour shows 1..8 in row order at h=0..3, v=0..1. `frame_done_o` pulses once; state returns to 1.
- Underflow: push 4 pixels only → row 0 shows 1..4, row 1 shows 0, `underflow_o`=1, `frame_done_o` still pulses.
- Overflow: push 9 pixels back-to-back while in PRIME → count saturates at 8, `overflow_o`=1, the 9th pixel is never displayed.
- Simultaneous push/pop at full during RUN → count stays 8, no overflow.
- Mid-frame reset during RUN (default SVGA params) → next clock: colour 0, FIFO empty, state 0, flags 0.
